fifo_wr_ctrl: RTL
=================

# fifo_wr_ctrl

Write-domain controller for the asynchronous FIFO. It owns the write pointer in binary and Gray form, addresses the dual-port RAM write port, and synchronizes the read-domain Gray pointer into clk_wr. From those it derives registered full, almost-full, fill level and a sticky overflow flag. It is the write-side counterpart of the read-domain pointer/empty logic and drives the RAM's write enable, full and address inputs.

## Interface
- Depth, 8: FIFO entries; power of two, ≥ 4.
- PtrWidth, $clog2(Depth): RAM address width.
- NSync, 2: synchronizer stages for the read pointer; ≥ 2.
- AlmostFullMargin, 2: almost-full asserts when level ≥ Depth − AlmostFullMargin; range 1..Depth−1.

Ports:
- clk_wr  in  1  write clock.
- rst_sync_n  in  1  reset, asynchronous, active-low; clock clk_wr.
- i_wr_en  in  1  write request.
- i_rd_gray_ptr  in  PtrWidth+1  read-domain Gray pointer; asynchronous to clk_wr.
- i_clr_overflow  in  1  clears o_overflow.
- o_wr_ptr  out  PtrWidth  RAM write address; low bits of the binary pointer.
- o_wr_gray_ptr  out  PtrWidth+1  registered Gray write pointer, sent to the read domain.
- o_wr_full  out  1  FIFO full.
- o_wr_almost_full  out  1  level ≥ Depth − AlmostFullMargin.
- o_wr_level  out  PtrWidth+1  occupied entries, 0..Depth; pessimistic.
- o_overflow  out  1  sticky: a write was attempted while full.

## Operation
- Accept = i_wr_en && !o_wr_full. On each accepting edge, wbin advances by 1 modulo 2·Depth. wgray = wbin ^ (wbin >> 1). Both are registered.
- No accept: pointers hold. The RAM write for the accepted entry uses the pre-increment o_wr_ptr on the same edge.
- rq = i_rd_gray_ptr after NSync flops. rbin = gray-to-binary of rq.
- Next pointers: wbin_n = wbin + accept; wgray_n = bin2gray(wbin_n).
- o_wr_full is registered: (wgray_n == {~rq[PtrWidth:PtrWidth-1], rq[PtrWidth-2:0]}).
- o_wr_level is registered: (wbin_n − rbin) mod 2·Depth, PtrWidth+1 bits, unsigned.
- o_wr_almost_full is registered: level_n ≥ Depth − AlmostFullMargin.
- o_overflow is set on any edge with i_wr_en && o_wr_full. It clears on i_clr_overflow. If set and clear occur on the same edge, set wins.
- Reset, asynchronous: all pointers, all synchronizer flops, o_wr_full, o_wr_almost_full, o_wr_level and o_overflow go to 0. Any reset mid-operation discards all state; the read side is reset by the same system reset.
- No state machine; the block is a counter plus compare.

## Timing
- Full asserts at the edge that accepts the Depth-th unread entry, so a write in the following cycle is blocked. Latency is 0 cycles of overshoot.
- Read-side frees are seen at o_wr_full, o_wr_level and o_wr_almost_full exactly NSync+1 clk_wr edges after i_rd_gray_ptr changes (settled before edge 1).
- Simultaneous accept and read-pointer update: both apply in the same level_n. The net level is unchanged if they balance.
- o_wr_gray_ptr changes by exactly one bit per accept, including the wrap 2·Depth−1 → 0.
- The read-side Gray pointer may change asynchronously; only its single-bit-change property is relied on.

## Structure
- Shared package fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterized by width;
  - the common pointer-width constant convention (PtrWidth+1 for wrap bit).
- The read-domain controller reuses fifo_pkg.
- Sub-module gray_ptr_sync: NSync-stage multi-bit flop synchronizer with async active-low reset to 0. It is instantiated once for i_rd_gray_ptr and is reusable in the read domain.

## Test plan
Configuration for all scenarios: Depth=8, NSync=2, AlmostFullMargin=2.
- Reset: assert rst_sync_n=0 mid-stream → all outputs 0 immediately; after release, first write goes to o_wr_ptr=0.
- Fill with i_rd_gray_ptr=0, 8 back-to-back writes →
  - o_wr_almost_full=1 after 6th accept;
  - o_wr_full=1 after 8th accept;
  - o_wr_level=8, o_wr_ptr=0, o_wr_gray_ptr=4'b1100.
- Write while full: i_wr_en=1 for 3 cycles → pointers unchanged, o_overflow=1 and held; pulse i_clr_overflow → o_overflow=0 next edge.
- Drain visibility: from full, set i_rd_gray_ptr=4'b0001 → o_wr_full=0 and o_wr_level=7 exactly 3 edges later; o_wr_almost_full stays 1.
- Wrap-around: 40 writes with the read pointer tracking 4 entries behind →
  - o_wr_gray_ptr single-bit steps through 4'b1000 → 4'b0000;
  - o_wr_full never set.
- Simultaneous: at level 7, write plus read-pointer advance → level stays 7; full never asserts.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both clock domains of the asynchronous FIFO.
// Pointers carry one wrap bit above the RAM address bits.
package fifo_pkg;

  localparam int unsigned PtrWordW = 32;
  typedef logic [PtrWordW-1:0] ptr_word_t;

  // Full pointer width (address bits plus wrap bit) for a given depth.
  function automatic int unsigned ptr_full_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Narrower pointers are zero-extended by the caller and cast back afterwards.
  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin = '0;
    bin[PtrWordW-1] = gray[PtrWordW-1];
    for (int i = PtrWordW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-bit flop synchronizer for a Gray-coded pointer crossing clock domains.
// Relies on the source changing at most one bit per update.
module gray_ptr_sync #(
  parameter int unsigned Width = 4,
  parameter int unsigned NSync = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [NSync];

  genvar gi;
  generate
    for (gi = 0; gi < NSync; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) stage_q[gi] <= '0;
          else          stage_q[gi] <= d_i;
        end
      end else begin : g_next
        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) stage_q[gi] <= '0;
          else          stage_q[gi] <= stage_q[gi-1];
        end
      end
    end
  endgenerate

  assign q_o = stage_q[NSync-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer, full/almost-full, fill level and sticky overflow
// logic of the asynchronous FIFO.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned Depth            = 8,
  parameter int unsigned PtrWidth         = $clog2(Depth),
  parameter int unsigned NSync            = 2,
  parameter int unsigned AlmostFullMargin = 2
) (
  input  logic                clk_wr,
  input  logic                rst_sync_n,
  input  logic                i_wr_en,
  input  logic [PtrWidth:0]   i_rd_gray_ptr,
  input  logic                i_clr_overflow,
  output logic [PtrWidth-1:0] o_wr_ptr,
  output logic [PtrWidth:0]   o_wr_gray_ptr,
  output logic                o_wr_full,
  output logic                o_wr_almost_full,
  output logic [PtrWidth:0]   o_wr_level,
  output logic                o_overflow
);

  typedef logic [PtrWidth:0] ptr_t;

  localparam ptr_t AfThresh = ptr_t'(Depth - AlmostFullMargin);

  ptr_t wbin_q, wbin_d;
  ptr_t wgray_q, wgray_d;
  ptr_t level_q, level_d;
  ptr_t rq, rbin, full_pattern;
  logic full_q, full_d;
  logic afull_q, afull_d;
  logic ovf_q, ovf_d;
  logic accept;

  gray_ptr_sync #(
    .Width (PtrWidth + 1),
    .NSync (NSync)
  ) u_rd_ptr_sync (
    .clk_i   (clk_wr),
    .rst_n_i (rst_sync_n),
    .d_i     (i_rd_gray_ptr),
    .q_o     (rq)
  );

  always_comb begin
    accept  = i_wr_en && !full_q;
    wbin_d  = wbin_q + ptr_t'(accept);
    wgray_d = ptr_t'(bin2gray(ptr_word_t'(wbin_d)));
    rbin    = ptr_t'(gray2bin(ptr_word_t'(rq)));
    // Write pointer exactly Depth ahead: top two Gray bits inverted, rest equal.
    full_pattern = {~rq[PtrWidth:PtrWidth-1], rq[PtrWidth-2:0]};
    full_d  = (wgray_d == full_pattern);
    level_d = wbin_d - rbin;
    afull_d = (level_d >= AfThresh);
    // Set dominates clear when both happen on the same edge.
    ovf_d   = (i_wr_en && full_q) || (ovf_q && !i_clr_overflow);
  end

  always_ff @(posedge clk_wr or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_wr_ptr         = wbin_q[PtrWidth-1:0];
  assign o_wr_gray_ptr    = wgray_q;
  assign o_wr_full        = full_q;
  assign o_wr_almost_full = afull_q;
  assign o_wr_level       = level_q;
  assign o_overflow       = ovf_q;

endmodule
